pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Controls the program counter for the pipelined RISC-V core.
- Selects the next PC from sequential, jump (ID) and branch (EX) sources with fixed priority.
- Applies the instruction-memory fetch handshake and hazard-unit stalls, and issues IF/ID flushes.
- Holds one pending redirect while a stall is asserted.

Parameters:
ADDR_WIDTH, 12, width of all PC/target buses
OFFSET, 4, sequential increment in bytes
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  core clock, all state updates on posedge
triggerRst  input  1  synchronous active-high reset
stall  input  1  hazard unit freeze; PC must not change
imemReady  input  1  instruction memory accepts/returns fetch at pc this cycle
branchTaken  input  1  EX-stage resolved taken branch
branchTarget  input  ADDR_WIDTH  branch destination
jumpEn  input  1  ID-stage JAL/JALR redirect
jumpTarget  input  ADDR_WIDTH  jump destination
pc  output  ADDR_WIDTH  current fetch address (registered)
incPC  output  ADDR_WIDTH  pc + OFFSET, combinational, modulo 2^ADDR_WIDTH
fetchReq  output  1  fetch request valid at pc
flushIF  output  1  kill instruction in IF/ID register
flushID  output  1  kill instruction in ID/EX register
redirectPending  output  1  pending redirect held
misalignErr  output  1  sticky misaligned-target flag (see Optional Feature)

Behaviour:
- Reset (triggerRst high at posedge, overrides all inputs): pc=RESET_PC, state=BOOT, pendReg=0, redirectPending=0, misalignErr=0.
- fetchReq, flushIF and flushID are combinational and are 0 in BOOT.
- States:
  - BOOT: fetchReq=0 for exactly one cycle, then FETCH unconditionally (stall ignored).
  - FETCH: fetchReq=1.
  - HOLD: fetchReq=0; a redirect is latched.
- Redirect select, priority branchTaken > jumpEn:
  - branch: flushIF=1 and flushID=1 in the same cycle.
  - jump only: flushIF=1, flushID=0.
  - Flushes are combinational and asserted regardless of stall.
- FETCH update at posedge:
  - redirect && !stall: pc<=selected target (imemReady ignored; the outstanding response is discarded by flushIF).
  - redirect && stall: pendReg<=selected target, redirectPending<=1, pc holds, next state HOLD.
  - no redirect && imemReady && !stall: pc<=incPC.
  - Otherwise pc holds.
- HOLD:
  - Flush outputs 0.
  - branchTaken overwrites pendReg; jumpEn is ignored.
  - First cycle with stall=0: pc<=pendReg, redirectPending<=0, next state FETCH.
- Wrap-around: incPC and pc wrap modulo 2^ADDR_WIDTH with no error.
- Reset in HOLD: the pending redirect is discarded.
- Latency: redirect-to-pc is 1 cycle unstalled, or 1 cycle after stall release.

Optional Feature:
PC_ALIGN_CHECK_EN
- Defined:
  - A selected target with target[1:0]!=0 is not applied; pc holds.
  - misalignErr is set sticky until reset.
  - flushIF/flushID still assert.
- Undefined: targets are applied unmodified and misalignErr is tied to 0.

Decomposition:
- Package pc_seq_pkg: state enum (BOOT, FETCH, HOLD), redirect-source enum (SRC_SEQ, SRC_JUMP, SRC_BRANCH), default RESET_PC/OFFSET constants.
- Sub-module pc_target_mux: combinational priority select producing the target, source code and flush pair; it is instantiated once.

Test Plan:
- Reset then 4 cycles with imemReady=1, stall=0 -> pc sequence 0 (BOOT), 0, 4, 8, 12; fetchReq=0 only in the BOOT cycle.
- At pc=0x010, jumpEn=1, jumpTarget=0x100, branchTaken=1, branchTarget=0x200 -> flushIF=1, flushID=1 that cycle; next pc=0x200.
- At pc=0x020, branchTaken=1, target=0x080, stall=1 for 3 cycles -> redirectPending=1, pc stays 0x020, fetchReq=0 during HOLD; pc=0x080 one cycle after stall drops.
- imemReady=0 for 2 cycles at pc=0x030, no redirect -> pc holds 0x030; advances to 0x034 on the first cycle imemReady=1.
- pc=0xFFC, sequential step -> pc=0x000; triggerRst asserted in HOLD -> pc=0x000, redirectPending=0 next cycle.
- With PC_ALIGN_CHECK_EN: jumpTarget=0x102 -> pc holds and misalignErr=1 until reset; without the macro -> pc=0x102, misalignErr=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state/source enums and default constants for the PC sequencer
package pc_seq_pkg;
  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;
  typedef enum logic [1:0] {SRC_SEQ, SRC_JUMP, SRC_BRANCH} src_t;
  localparam int DEF_RESET_PC = 0;
  localparam int DEF_OFFSET = 4;
endpackage

// File: rtl/pc_target_mux.sv
// pc_target_mux: fixed-priority redirect select (branch > jump) with IF/ID flush pair
module pc_target_mux
  import pc_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  en,
  input  logic                  branchTaken,
  input  logic [ADDR_WIDTH-1:0] branchTarget,
  input  logic                  jumpEn,
  input  logic [ADDR_WIDTH-1:0] jumpTarget,
  output logic [ADDR_WIDTH-1:0] target,
  output src_t                  src,
  output logic                  flush_if,
  output logic                  flush_id
);
  always_comb begin
    target   = branchTaken ? branchTarget : jumpTarget;
    src      = !en ? SRC_SEQ : branchTaken ? SRC_BRANCH : jumpEn ? SRC_JUMP : SRC_SEQ;
    flush_if = en && (branchTaken || jumpEn);
    flush_id = en && branchTaken;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC control with fetch handshake, stalls and one pending redirect.
// Define PC_ALIGN_CHECK_EN to reject misaligned targets and raise sticky misalignErr.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int OFFSET     = DEF_OFFSET,
  parameter int RESET_PC   = DEF_RESET_PC
) (
  input  logic                  clk,
  input  logic                  triggerRst,
  input  logic                  stall,
  input  logic                  imemReady,
  input  logic                  branchTaken,
  input  logic [ADDR_WIDTH-1:0] branchTarget,
  input  logic                  jumpEn,
  input  logic [ADDR_WIDTH-1:0] jumpTarget,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] incPC,
  output logic                  fetchReq,
  output logic                  flushIF,
  output logic                  flushID,
  output logic                  redirectPending,
  output logic                  misalignErr
);
  state_t                state;
  src_t                  src;
  logic [ADDR_WIDTH-1:0] target, pend, hold_tgt;
  logic                  redirect, tgt_bad, hold_bad;
  pc_target_mux #(.ADDR_WIDTH(ADDR_WIDTH)) u_mux (
    .en(state == FETCH),
    .branchTaken(branchTaken),
    .branchTarget(branchTarget),
    .jumpEn(jumpEn),
    .jumpTarget(jumpTarget),
    .target(target),
    .src(src),
    .flush_if(flushIF),
    .flush_id(flushID)
  );
  // in HOLD a fresh branch supersedes the latched redirect, even on the release cycle
  assign hold_tgt = branchTaken ? branchTarget : pend;
  assign redirect = src != SRC_SEQ;
  assign incPC    = pc + ADDR_WIDTH'(OFFSET);
  assign fetchReq = state == FETCH;
`ifdef PC_ALIGN_CHECK_EN
  assign tgt_bad  = |target[1:0];
  assign hold_bad = |hold_tgt[1:0];
`else
  assign tgt_bad  = 1'b0;
  assign hold_bad = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (triggerRst) begin
      pc              <= ADDR_WIDTH'(RESET_PC);
      state           <= BOOT;
      pend            <= '0;
      redirectPending <= 1'b0;
      misalignErr     <= 1'b0;
    end else if (state == BOOT) begin
      state <= FETCH;
    end else if (state == FETCH) begin
      if (redirect && stall) begin
        pend            <= target;
        redirectPending <= 1'b1;
        state           <= HOLD;
      end else if (redirect) begin
        if (tgt_bad) misalignErr <= 1'b1;
        else pc <= target;
      end else if (imemReady && !stall) begin
        pc <= incPC;
      end
    end else if (stall) begin
      pend <= hold_tgt;
    end else begin
      if (hold_bad) misalignErr <= 1'b1;
      else pc <= hold_tgt;
      redirectPending <= 1'b0;
      state           <= FETCH;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
  logic        clk = 0;
  logic        triggerRst, stall, imemReady, branchTaken, jumpEn;
  logic [11:0] branchTarget, jumpTarget, pc, incPC;
  logic        fetchReq, flushIF, flushID, redirectPending, misalignErr;
  int          tests = 0, failed = 0;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif
  pc_sequencer dut (
    .clk(clk), .triggerRst(triggerRst), .stall(stall), .imemReady(imemReady),
    .branchTaken(branchTaken), .branchTarget(branchTarget),
    .jumpEn(jumpEn), .jumpTarget(jumpTarget),
    .pc(pc), .incPC(incPC), .fetchReq(fetchReq), .flushIF(flushIF), .flushID(flushID),
    .redirectPending(redirectPending), .misalignErr(misalignErr)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    triggerRst = 1; stall = 0; imemReady = 0; branchTaken = 0; jumpEn = 0;
    branchTarget = 0; jumpTarget = 0;
    step();
    triggerRst = 0; imemReady = 1;
    check("boot_pc", pc, 0);
    check("boot_fetch", fetchReq, 0);
    check("boot_pend", redirectPending, 0);
    check("boot_err", misalignErr, 0);
    check("boot_flush", {flushIF, flushID}, 0);
    step();
    check("seq0_pc", pc, 0);
    check("seq0_fetch", fetchReq, 1);
    check("seq0_inc", incPC, 12'h004);
    step(); check("seq1_pc", pc, 12'h004);
    step(); check("seq2_pc", pc, 12'h008);
    step(); check("seq3_pc", pc, 12'h00C);
    step(); check("seq4_pc", pc, 12'h010);
    jumpEn = 1; jumpTarget = 12'h100; branchTaken = 1; branchTarget = 12'h200;
    #1 check("prio_flush", {flushIF, flushID}, 2'b11);
    step(); check("prio_pc", pc, 12'h200);
    branchTaken = 0; jumpTarget = 12'h020;
    #1 check("jump_flush", {flushIF, flushID}, 2'b10);
    step(); check("jump_pc", pc, 12'h020);
    jumpEn = 0; branchTaken = 1; branchTarget = 12'h080; stall = 1;
    #1 check("stall_br_flush", {flushIF, flushID}, 2'b11);
    step();
    check("hold1_pend", redirectPending, 1);
    check("hold1_pc", pc, 12'h020);
    check("hold1_fetch", fetchReq, 0);
    branchTaken = 0; jumpEn = 1; jumpTarget = 12'h300;
    #1 check("hold_flush", {flushIF, flushID}, 2'b00);
    step();
    check("hold2_pc", pc, 12'h020);
    jumpEn = 0;
    step();
    check("hold3_pc", pc, 12'h020);
    check("hold3_pend", redirectPending, 1);
    stall = 0;
    step();
    check("release_pc", pc, 12'h080);
    check("release_pend", redirectPending, 0);
    check("release_fetch", fetchReq, 1);
    jumpEn = 1; jumpTarget = 12'h030;
    step(); check("to30_pc", pc, 12'h030);
    jumpEn = 0; imemReady = 0;
    step(); check("nrdy1_pc", pc, 12'h030);
    step(); check("nrdy2_pc", pc, 12'h030);
    imemReady = 1;
    step(); check("rdy_pc", pc, 12'h034);
    stall = 1;
    step(); check("stall_seq_pc", pc, 12'h034);
    check("stall_seq_fetch", fetchReq, 1);
    stall = 0; jumpEn = 1; jumpTarget = 12'hFFC;
    step(); check("toFFC_pc", pc, 12'hFFC);
    check("wrap_inc", incPC, 12'h000);
    jumpEn = 0;
    step(); check("wrap_pc", pc, 12'h000);
    branchTaken = 1; branchTarget = 12'h040; stall = 1;
    step(); check("rh_pend", redirectPending, 1);
    branchTaken = 0; triggerRst = 1;
    step();
    check("rh_pc", pc, 0);
    check("rh_pend_clr", redirectPending, 0);
    check("rh_boot_fetch", fetchReq, 0);
    triggerRst = 0; stall = 0;
    step(); check("rh_fetch_pc", pc, 0);
    jumpEn = 1; jumpTarget = 12'h102;
    #1 check("mis_flush", {flushIF, flushID}, 2'b10);
    step();
    check("mis_pc", pc, ALIGN ? 12'h000 : 12'h102);
    check("mis_err", misalignErr, ALIGN);
    jumpEn = 0;
    step();
    check("mis_err_sticky", misalignErr, ALIGN);
    triggerRst = 1;
    step();
    check("mis_err_rst", misalignErr, 0);
    triggerRst = 0;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
